// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
// Op encodings follow the funct3 field of the M extension.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } muldiv_state_e;

  function automatic int iter_count(
    input int xlen,
    input int bpc
  );
    return xlen / bpc;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 step: shift-add multiply or restoring divide.
// {hi,lo} is the product/remainder:quotient pair.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            i_div,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_opd,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_sh;
  logic [XLEN:0] w_diff;

  assign w_sum = {1'b0, i_hi}
               + ({1'b0, i_opd} & {(XLEN+1){i_lo[0]}});
  assign w_sh   = {i_hi, i_lo[XLEN-1]};
  assign w_diff = w_sh - {1'b0, i_opd};

  always_comb begin
    o_hi = w_sum[XLEN:1];
    o_lo = {w_sum[0], i_lo[XLEN-1:1]};
    if (i_div) begin
      // Remainder stays below divisor, so the borrow bit is the sign.
      if (w_diff[XLEN]) begin
        o_hi = w_sh[XLEN-1:0];
        o_lo = {i_lo[XLEN-2:0], 1'b0};
      end else begin
        o_hi = w_diff[XLEN-1:0];
        o_lo = {i_lo[XLEN-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/iterative_muldiv.sv
// Multi-cycle RV32M multiply/divide unit for the execute stage.
// Works on magnitudes, then fixes signs in a single FIX cycle.
module iterative_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int ITER = iter_count(XLEN, BITS_PER_CYCLE);
  localparam int CW   = $clog2(ITER + 1);

  if (!((BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
         BITS_PER_CYCLE == 4) &&
        (XLEN % BITS_PER_CYCLE == 0))) begin : g_bad_cfg
    $error("iterative_muldiv: illegal BITS_PER_CYCLE");
  end

  muldiv_state_e   r_state;
  muldiv_state_e   w_next;
  muldiv_op_e      r_op;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_opd;
  logic [XLEN-1:0] r_result;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [CW-1:0]   r_cnt;

  muldiv_op_e      w_op;
  logic            w_a_sgn;
  logic            w_b_sgn;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_b_zero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_spec_val;
  logic            w_accept;

  assign w_op    = muldiv_op_e'(op);
  assign w_mag_a = w_a_sgn ? -a : a;
  assign w_mag_b = w_b_sgn ? -b : b;

  always_comb begin
    w_a_sgn = 1'b0;
    w_b_sgn = 1'b0;
    unique case (1'b1)
      (w_op == OP_MUL), (w_op == OP_MULH),
      (w_op == OP_DIV), (w_op == OP_REM): begin
        w_a_sgn = a[XLEN-1];
        w_b_sgn = b[XLEN-1];
      end
      (w_op == OP_MULHSU): w_a_sgn = a[XLEN-1];
      default: ;
    endcase
  end

  assign w_b_zero = (b == '0);
  assign w_ovf    = (w_op == OP_DIV || w_op == OP_REM)
                  && (a == {1'b1, {(XLEN-1){1'b0}}})
                  && (b == '1);
  assign w_special = op[2] && (w_b_zero || w_ovf);

  // op[1] separates REM/REMU from DIV/DIVU
  always_comb begin
    w_spec_val = '0;
    if (w_b_zero) w_spec_val = op[1] ? a : '1;
    else          w_spec_val = op[1] ? '0 : a;
  end

  assign ready    = (r_state == IDLE) || (r_state == DONE);
  assign busy     = (r_state == CALC) || (r_state == FIX);
  assign done     = (r_state == DONE);
  assign result   = r_result;
  assign w_accept = ready && start && !flush;

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          w_next = IDLE;
          if (start) w_next = w_special ? DONE : CALC;
        end
        CALC: if (r_cnt == CW'(1)) w_next = FIX;
        FIX:  w_next = DONE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  logic [XLEN-1:0] w_hi [BITS_PER_CYCLE+1];
  logic [XLEN-1:0] w_lo [BITS_PER_CYCLE+1];
  logic            w_div;

  assign w_div   = r_op[2];
  assign w_hi[0] = r_hi;
  assign w_lo[0] = r_lo;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    muldiv_step #(
      .XLEN (XLEN)
    ) u_step (
      .i_div (w_div),
      .i_hi  (w_hi[i]),
      .i_lo  (w_lo[i]),
      .i_opd (r_opd),
      .o_hi  (w_hi[i+1]),
      .o_lo  (w_lo[i+1])
    );
  end

  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix;

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_quo    = r_neg_q ? -r_lo : r_lo;
  assign w_rem    = r_neg_r ? -r_hi : r_hi;

  always_comb begin
    w_fix = '0;
    unique case (r_op)
      OP_MUL:    w_fix = w_prod_s[XLEN-1:0];
      OP_MULH:   w_fix = w_prod_s[2*XLEN-1:XLEN];
      OP_MULHSU: w_fix = w_prod_s[2*XLEN-1:XLEN];
      OP_MULHU:  w_fix = r_hi;
      OP_DIV:    w_fix = w_quo;
      OP_DIVU:   w_fix = r_lo;
      OP_REM:    w_fix = w_rem;
      OP_REMU:   w_fix = r_hi;
      default:   w_fix = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op     <= OP_MUL;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opd    <= '0;
      r_result <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_op    <= w_op;
      r_neg_q <= w_a_sgn ^ w_b_sgn;
      r_neg_r <= w_a_sgn;
      r_hi    <= '0;
      r_lo    <= op[2] ? w_mag_a : w_mag_b;
      r_opd   <= op[2] ? w_mag_b : w_mag_a;
      r_cnt   <= CW'(ITER);
      if (w_special) r_result <= w_spec_val;
    end else if (r_state == CALC && !flush) begin
      r_hi  <= w_hi[BITS_PER_CYCLE];
      r_lo  <= w_lo[BITS_PER_CYCLE];
      r_cnt <= r_cnt - CW'(1);
    end else if (r_state == FIX && !flush) begin
      r_result <= w_fix;
    end
  end

endmodule

// File: tb/tb_iterative_muldiv.sv
// Directed bench for iterative_muldiv, radix-2 and 4-bit-per-cycle builds.
// Both instances share inputs; each check selects one instance's outputs.
module tb_iterative_muldiv;

  logic        clk;
  logic        reset;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready,  busy,  done;
  logic [31:0] result;
  logic        ready4, busy4, done4;
  logic [31:0] result4;

  int total = 0;
  int bad   = 0;

  iterative_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1)) u32 (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .flush(flush), .ready(ready),
    .busy(busy), .done(done), .result(result)
  );

  iterative_muldiv #(.XLEN(32), .BITS_PER_CYCLE(4)) u4 (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .flush(flush), .ready(ready4),
    .busy(busy4), .done(done4), .result(result4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input bit sel, input logic [2:0] o,
                       input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int nb, output int rv,
                       output logic [31:0] res);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    lat = 0; nb = 0; rv = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (sel ? busy4 : busy) nb++;
      if ((sel ? busy4 : busy) && (sel ? ready4 : ready)) rv++;
    end while (!(sel ? done4 : done) && lat < 100);
    res = sel ? result4 : result;
  endtask

  initial begin
    int lat, nb, rv, nd;
    logic [31:0] res;
    reset = 1'b0; start = 1'b0; flush = 1'b0;
    op = 3'd0; a = '0; b = '0;
    #2;
    chk("rst_flags", {29'd0, ready, busy, done}, 32'b100);
    chk("rst_result", result, 32'h0);
    chk("rst_flags4", {29'd0, ready4, busy4, done4}, 32'b100);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    do_op(0, 3'b000, 32'd7, 32'hFFFFFFFD, lat, nb, rv, res);
    chk("mul_res", res, 32'hFFFFFFEB);
    chk("mul_lat", lat, 34);
    chk("mul_busy", nb, 33);
    chk("mul_ready_busy", rv, 0);
    @(posedge clk); #1;
    chk("mul_done_pulse", {31'd0, done}, 32'd0);

    do_op(0, 3'b001, 32'h80000000, 32'h80000000, lat, nb, rv, res);
    chk("mulh", res, 32'h40000000);
    do_op(0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, nb, rv, res);
    chk("mulhu", res, 32'hFFFFFFFE);
    do_op(0, 3'b010, 32'hFFFFFFFF, 32'd2, lat, nb, rv, res);
    chk("mulhsu", res, 32'hFFFFFFFF);

    do_op(0, 3'b100, 32'hFFFFFFF9, 32'd2, lat, nb, rv, res);
    chk("div", res, 32'hFFFFFFFD);
    do_op(0, 3'b110, 32'hFFFFFFF9, 32'd2, lat, nb, rv, res);
    chk("rem", res, 32'hFFFFFFFF);
    do_op(0, 3'b101, 32'd100, 32'd7, lat, nb, rv, res);
    chk("divu", res, 32'd14);
    do_op(0, 3'b111, 32'd100, 32'd7, lat, nb, rv, res);
    chk("remu", res, 32'd2);

    do_op(0, 3'b101, 32'd5, 32'd0, lat, nb, rv, res);
    chk("divu_by0", res, 32'hFFFFFFFF);
    chk("divu_by0_lat", lat, 1);
    do_op(0, 3'b110, 32'd5, 32'd0, lat, nb, rv, res);
    chk("rem_by0", res, 32'd5);
    do_op(0, 3'b100, 32'h80000000, 32'hFFFFFFFF, lat, nb, rv, res);
    chk("div_ovf", res, 32'h80000000);
    chk("div_ovf_lat", lat, 1);
    do_op(0, 3'b110, 32'h80000000, 32'hFFFFFFFF, lat, nb, rv, res);
    chk("rem_ovf", res, 32'h0);

    do_op(0, 3'b000, 32'd3, 32'd5, lat, nb, rv, res);
    chk("mul_small", res, 32'd15);

    // flush during CALC cycle 10
    @(negedge clk);
    op = 3'b000; a = 32'd7; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_flags", {29'd0, ready, busy, done}, 32'b100);
    chk("flush_result", result, 32'd15);
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("flush_no_done", nd, 0);

    @(negedge clk);
    op = 3'b101; a = 32'd9; b = 32'd3;
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start", {29'd0, ready, busy, done}, 32'b100);

    // second start while busy must be ignored
    @(negedge clk);
    op = 3'b101; a = 32'd9; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    repeat (5) begin
      @(posedge clk); #1;
      lat++;
    end
    @(negedge clk);
    op = 3'b000; a = 32'd2; b = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat++;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("busy_start_lat", lat, 34);
    chk("busy_start_res", result, 32'd3);
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("busy_start_once", nd, 0);

    do_op(1, 3'b100, 32'd1000, 32'hFFFFFFF6, lat, nb, rv, res);
    chk("r4_div", res, 32'hFFFFFF9C);
    chk("r4_lat", lat, 10);
    chk("r4_busy", nb, 9);
    do_op(1, 3'b101, 32'd9, 32'd3, lat, nb, rv, res);
    chk("r4_b2b_res", res, 32'd3);
    chk("r4_b2b_lat", lat, 10);
    do_op(1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, nb, rv, res);
    chk("r4_mulhu", res, 32'hFFFFFFFE);

    // async reset mid-CALC
    @(negedge clk);
    op = 3'b000; a = 32'd7; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_flags", {29'd0, ready, busy, done}, 32'b100);
    chk("arst_result", result, 32'h0);
    chk("arst_flags4", {29'd0, ready4, busy4, done4}, 32'b100);
    chk("arst_result4", result4, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || done4) nd++;
    end
    chk("arst_no_done", nd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
